spi_reg_bank: RTL and testbench

//  Consumes 24-bit words from the SPI slave deserializer and applies them as register writes.

---
 rtl/spi_reg_bank.sv | 111 +++++++++++
 tb/tb_spi_reg_bank.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// Register bank fed by the SPI slave: header decode, single and auto-increment burst writes.
// Optional odd-parity check on bit 23 when SPI_REG_PARITY_EN is defined.
module spi_reg_bank #(
    parameter int          NREGS     = 16,
    parameter logic [15:0] RESET_VAL = 16'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [23:0]           word_in,
    input  logic                  word_valid,
    input  logic                  new_transfer,
    output logic [NREGS*16-1:0]   regs,
    output logic [NREGS-1:0]      reg_update,
    output logic                  busy,
    output logic [7:0]            err_count
);

    typedef enum logic [1:0] {S_HDR, S_BURST, S_DONE} state_t;

    localparam logic [5:0] LP_NREGS = 6'(NREGS);

    state_t                   r_state, w_state_nxt;
    logic [4:0]               r_ptr, w_ptr_nxt, w_wr_addr;
    logic                     w_wr_en, w_err, w_par_ok, w_hdr, w_addr_ok;
    logic [1:0]               w_op;
    logic [4:0]               w_addr;
    logic [NREGS-1:0][15:0]   r_regs;
    logic [NREGS-1:0]         r_upd;
    logic [7:0]               r_err;

`ifdef SPI_REG_PARITY_EN
    assign w_par_ok = ^word_in;
`else
    logic w_unused_par;
    assign w_unused_par = word_in[23];
    assign w_par_ok     = 1'b1;
`endif

    function automatic logic [4:0] f_inc(input logic [4:0] a);
        f_inc = (({1'b0, a} + 6'd1) >= LP_NREGS) ? 5'd0 : a + 5'd1;
    endfunction

    assign w_op      = word_in[22:21];
    assign w_addr    = word_in[20:16];
    assign w_addr_ok = {1'b0, w_addr} < LP_NREGS;
    // A word arriving with new_transfer is always treated as a header.
    assign w_hdr     = new_transfer || (r_state == S_HDR);

    always_comb begin
        w_state_nxt = new_transfer ? S_HDR : r_state;
        w_ptr_nxt   = new_transfer ? 5'd0 : r_ptr;
        w_wr_en     = 1'b0;
        w_wr_addr   = w_addr;
        w_err       = 1'b0;
        if (word_valid) begin
            if (!w_par_ok) begin
                w_err = 1'b1;
                if (w_hdr) w_state_nxt = S_DONE;
            end else if (w_hdr) begin
                w_state_nxt = S_DONE;
                case (w_op)
                    2'b00: w_state_nxt = S_DONE;
                    2'b01: begin
                        if (w_addr_ok) w_wr_en = 1'b1;
                        else           w_err   = 1'b1;
                    end
                    2'b10: begin
                        if (w_addr_ok) begin
                            w_wr_en     = 1'b1;
                            w_ptr_nxt   = f_inc(w_addr);
                            w_state_nxt = S_BURST;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                    default: w_err = 1'b1;
                endcase
            end else if (r_state == S_BURST) begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_ptr;
                w_ptr_nxt = f_inc(r_ptr);
            end else begin
                w_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_HDR;
            r_ptr   <= 5'd0;
            r_err   <= 8'd0;
            r_upd   <= '0;
            r_regs  <= {NREGS{RESET_VAL}};
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            if (w_err && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
            r_upd <= w_wr_en ? (NREGS'(1) << w_wr_addr) : '0;
            for (int i = 0; i < NREGS; i++) begin
                if (w_wr_en && (w_wr_addr == 5'(i))) r_regs[i] <= word_in[15:0];
            end
        end
    end

    assign regs       = r_regs;
    assign reg_update = r_upd;
    assign busy       = (r_state == S_BURST);
    assign err_count  = r_err;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed scenarios plus a randomized run against a reference model.
module tb_spi_reg_bank;
    localparam int          NREGS = 16;
    localparam logic [15:0] RV    = 16'h1234;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [23:0]          word_in = '0;
    logic                 word_valid = 1'b0;
    logic                 new_transfer = 1'b0;
    logic [NREGS*16-1:0]  regs;
    logic [NREGS-1:0]     reg_update;
    logic                 busy;
    logic [7:0]           err_count;

    int n_cmp = 0;
    int n_mis = 0;

    // reference model: mode 0 = expecting header, 1 = bursting, 2 = done
    logic [15:0]      m_regs [NREGS];
    int               m_mode;
    int               m_ptr;
    int               m_err;
    logic [NREGS-1:0] m_upd;

    spi_reg_bank #(.NREGS(NREGS), .RESET_VAL(RV)) dut (
        .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
        .new_transfer(new_transfer), .regs(regs), .reg_update(reg_update),
        .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout reached");
        $fatal(1);
    end

    function automatic logic [23:0] mkw(input logic [22:0] body);
`ifdef SPI_REG_PARITY_EN
        mkw = {~(^body), body};
`else
        mkw = {1'($urandom), body};
`endif
    endfunction

    function automatic bit par_ok(input logic [23:0] w);
`ifdef SPI_REG_PARITY_EN
        par_ok = (^w) == 1'b1;
`else
        par_ok = 1'b1;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = RV;
        m_mode = 0; m_ptr = 0; m_err = 0; m_upd = '0;
    endtask

    task automatic model_bump();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_write(input int a, input logic [15:0] d);
        m_regs[a] = d;
        m_upd = NREGS'(1) << a;
    endtask

    task automatic model_step(input logic [23:0] w, input bit v, input bit nt);
        int op, a;
        m_upd = '0;
        if (nt) begin m_mode = 0; m_ptr = 0; end
        if (v) begin
            op = int'(w[22:21]);
            a  = int'(w[20:16]);
            if (!par_ok(w)) begin
                model_bump();
                if (m_mode == 0) m_mode = 2;
            end else if (m_mode == 0) begin
                m_mode = 2;
                if (op == 0) begin
                end else if (op == 3 || a >= NREGS) begin
                    model_bump();
                end else begin
                    model_write(a, w[15:0]);
                    if (op == 2) begin m_ptr = (a + 1) % NREGS; m_mode = 1; end
                end
            end else if (m_mode == 1) begin
                model_write(m_ptr, w[15:0]);
                m_ptr = (m_ptr + 1) % NREGS;
            end else begin
                model_bump();
            end
        end
    endtask

    // called at a negedge; returns at the following negedge
    task automatic cycle(input logic [23:0] w, input bit v, input bit nt);
        word_in = w; word_valid = v; new_transfer = nt;
        model_step(w, v, nt);
        @(posedge clk);
        @(negedge clk);
        word_valid = 1'b0; new_transfer = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < NREGS; i++) begin
            n_cmp++;
            if (regs[16*i +: 16] !== RV) begin
                n_mis++; $display("FAIL reset_reg%0d got %h exp %h", i, regs[16*i +: 16], RV);
            end
        end
        n_cmp++;
        if (reg_update !== '0 || busy !== 1'b0 || err_count !== 8'd0) begin
            n_mis++; $display("FAIL reset_ctrl got upd=%h busy=%b err=%0d exp 0/0/0", reg_update, busy, err_count);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

`ifdef SPI_REG_PARITY_EN
    task automatic test_parity();
        int e0;
        e0 = m_err;
        cycle(24'h0, 0, 1);
        cycle(24'h23BEEF, 1, 0);
        n_cmp++;
        if (regs[3*16 +: 16] !== m_regs[3] || regs[3*16 +: 16] !== RV) begin
            n_mis++; $display("FAIL parity_bad_reg3 got %h exp %h", regs[3*16 +: 16], RV);
        end
        n_cmp++;
        if (err_count !== 8'(e0 + 1)) begin
            n_mis++; $display("FAIL parity_bad_err got %0d exp %0d", err_count, e0 + 1);
        end
        cycle(24'h0, 0, 1);
        cycle(24'hA3BEEF, 1, 0);
        n_cmp++;
        if (regs[3*16 +: 16] !== 16'hBEEF || reg_update !== 16'h0008) begin
            n_mis++; $display("FAIL parity_good got reg3=%h upd=%h exp BEEF/0008", regs[3*16 +: 16], reg_update);
        end
    endtask
`endif

    task automatic test_single();
        int e0;
        cycle(24'h0, 0, 1);
        cycle(mkw(23'h23BEEF), 1, 0);
        n_cmp++;
        if (regs[3*16 +: 16] !== 16'hBEEF || reg_update !== 16'h0008 || busy !== 1'b0) begin
            n_mis++; $display("FAIL single got reg3=%h upd=%h busy=%b exp BEEF/0008/0", regs[3*16 +: 16], reg_update, busy);
        end
        cycle(24'h0, 0, 0);
        n_cmp++;
        if (reg_update !== '0) begin
            n_mis++; $display("FAIL single_pulse got upd=%h exp 0000", reg_update);
        end
        e0 = m_err;
        cycle(mkw(23'h215555), 1, 0);
        n_cmp++;
        if (err_count !== 8'(e0 + 1) || regs[1*16 +: 16] !== m_regs[1] || reg_update !== '0) begin
            n_mis++; $display("FAIL done_drop got err=%0d reg1=%h upd=%h exp %0d/%h/0", err_count, regs[1*16 +: 16], reg_update, e0 + 1, m_regs[1]);
        end
    endtask

    task automatic test_burst_wrap();
        cycle(24'h0, 0, 1);
        cycle(mkw(23'h4E0001), 1, 0);
        n_cmp++;
        if (busy !== 1'b1 || reg_update !== 16'h4000) begin
            n_mis++; $display("FAIL burst_hdr got busy=%b upd=%h exp 1/4000", busy, reg_update);
        end
        cycle(mkw(23'h000002), 1, 0);
        cycle(mkw(23'h000003), 1, 0);
        n_cmp++;
        if (regs[14*16 +: 16] !== 16'h0001 || regs[15*16 +: 16] !== 16'h0002 || regs[15:0] !== 16'h0003) begin
            n_mis++; $display("FAIL burst_wrap got r14=%h r15=%h r0=%h exp 0001/0002/0003", regs[14*16 +: 16], regs[15*16 +: 16], regs[15:0]);
        end
        n_cmp++;
        if (busy !== 1'b1 || reg_update !== 16'h0001) begin
            n_mis++; $display("FAIL burst_busy got busy=%b upd=%h exp 1/0001", busy, reg_update);
        end
    endtask

    task automatic test_errors();
        int e0;
        e0 = m_err;
        cycle(24'h0, 0, 1);
        cycle(mkw(23'h7F0000), 1, 0);
        n_cmp++;
        if (reg_update !== '0 || busy !== 1'b0) begin
            n_mis++; $display("FAIL reserved_op got upd=%h busy=%b exp 0/0", reg_update, busy);
        end
        cycle(24'h0, 0, 1);
        cycle(mkw(23'h340000), 1, 0);
        n_cmp++;
        if (reg_update !== '0 || err_count !== 8'(e0 + 2)) begin
            n_mis++; $display("FAIL bad_addr got upd=%h err=%0d exp 0/%0d", reg_update, err_count, e0 + 2);
        end
    endtask

    task automatic test_reset_midburst();
        cycle(24'h0, 0, 1);
        cycle(mkw(23'h4A5555), 1, 0);
        cycle(mkw(23'h001111), 1, 0);
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || regs[10*16 +: 16] !== RV || err_count !== 8'd0) begin
            n_mis++; $display("FAIL async_reset got busy=%b r10=%h err=%0d exp 0/%h/0", busy, regs[10*16 +: 16], err_count, RV);
        end
        model_reset();
        @(negedge clk);
        // a word presented while reset is held must be lost
        word_in = mkw(23'h210055); word_valid = 1'b1; new_transfer = 1'b1;
        @(posedge clk);
        @(negedge clk);
        word_valid = 1'b0; new_transfer = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        cycle(mkw(23'h2100AA), 1, 1);
        for (int i = 0; i < NREGS; i++) begin
            n_cmp++;
            if (regs[16*i +: 16] !== ((i == 1) ? 16'h00AA : RV)) begin
                n_mis++; $display("FAIL midburst_reg%0d got %h exp %h", i, regs[16*i +: 16], (i == 1) ? 16'h00AA : RV);
            end
        end
        n_cmp++;
        if (err_count !== 8'd0 || reg_update !== 16'h0002) begin
            n_mis++; $display("FAIL midburst_ctrl got err=%0d upd=%h exp 0/0002", err_count, reg_update);
        end
    endtask

    task automatic test_random();
        logic [22:0] body;
        logic [23:0] w;
        bit v, nt;
        for (int c = 0; c < 400; c++) begin
            nt   = ($urandom % 8) == 0;
            v    = ($urandom % 2) == 1;
            body = {2'($urandom), 5'($urandom % 24), 16'($urandom)};
            w    = mkw(body);
`ifdef SPI_REG_PARITY_EN
            if (($urandom % 8) == 0) w[23] = ~w[23];
`endif
            cycle(w, v, nt);
            for (int i = 0; i < NREGS; i++) begin
                n_cmp++;
                if (regs[16*i +: 16] !== m_regs[i]) begin
                    n_mis++; $display("FAIL rand_c%0d_reg%0d got %h exp %h", c, i, regs[16*i +: 16], m_regs[i]);
                end
            end
            n_cmp++;
            if (reg_update !== m_upd || busy !== (m_mode == 1) || err_count !== 8'(m_err)) begin
                n_mis++; $display("FAIL rand_c%0d_ctrl got upd=%h busy=%b err=%0d exp %h/%b/%0d",
                                  c, reg_update, busy, err_count, m_upd, m_mode == 1, m_err);
            end
        end
    endtask

    task automatic test_saturation();
        cycle(24'h0, 0, 1);
        cycle(mkw(23'h000000), 1, 0);
        repeat (260) cycle(mkw(23'($urandom)), 1, 0);
        n_cmp++;
        if (err_count !== 8'hFF || m_err != 255) begin
            n_mis++; $display("FAIL err_saturate got %0d exp 255", err_count);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
`ifdef SPI_REG_PARITY_EN
        test_parity();
`endif
        test_single();
        test_burst_wrap();
        test_errors();
        test_reset_midburst();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
